// File: rtl/fp_encode_seq_pkg.sv
// ---------------------------------------------------------------------------
// fp_encode_seq_pkg
// Shared definitions for the two's-complement to floating-point encoder:
// default widths, FSM state encoding and small width helper functions.
// ---------------------------------------------------------------------------
package fp_encode_seq_pkg;

   localparam int DEF_IN_W   = 12;
   localparam int DEF_EXP_W  = 3;
   localparam int DEF_MANT_W = 4;

   // Largest representable exponent at the default exponent width.
   localparam int EXP_MAX = (1 << DEF_EXP_W) - 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      NORM = 2'd1,
      DONE = 2'd2
   } state_t;

   // Largest exponent for an arbitrary exponent width.
   function automatic int exp_max_of(input int exp_w);
      return (1 << exp_w) - 1;
   endfunction

   // Counter width able to hold the initial shift budget IN_W-MANT_W.
   function automatic int cnt_w_of(input int in_w, input int mant_w);
      return $clog2(in_w - mant_w + 1);
   endfunction

endpackage

// File: rtl/fp_round.sv
// ---------------------------------------------------------------------------
// fp_round
// Combinational round-to-nearest and exponent saturation for the encoder.
// Ports:
//   f0  in  MANT_W  truncated significand (top MANT_W bits of normalised mag)
//   rb  in  1       round bit (first bit below the significand)
//   cnt in  CNT_W   exponent before rounding
//   e   out EXP_W   final exponent
//   f   out MANT_W  final significand
// ---------------------------------------------------------------------------
module fp_round
   import fp_encode_seq_pkg::*;
#(
   parameter int EXP_W  = DEF_EXP_W,
   parameter int MANT_W = DEF_MANT_W,
   parameter int CNT_W  = 4
) (
   input  logic [MANT_W-1:0] f0,
   input  logic              rb,
   input  logic [CNT_W-1:0]  cnt,
   output logic [EXP_W-1:0]  e,
   output logic [MANT_W-1:0] f
);

   localparam int EMAX = exp_max_of(EXP_W);
   // One bit wider than either operand so the carry-incremented exponent
   // can be compared against EMAX without wrapping.
   localparam int W    = ((CNT_W > EXP_W) ? CNT_W : EXP_W) + 1;

   logic              carry;
   logic [W-1:0]      e_wide;
   logic [MANT_W-1:0] f_round;

   // Rounding an all-ones significand overflows: renormalise to 100..0
   // and bump the exponent instead.
   assign carry = rb & (&f0);

   always_comb begin
      e_wide  = W'(cnt) + W'(carry);
      f_round = carry ? {1'b1, {(MANT_W-1){1'b0}}} : (f0 + MANT_W'(rb));
      if (e_wide > W'(EMAX)) begin
         e = EXP_W'(EMAX);
         f = {MANT_W{1'b1}};
      end else begin
         e = e_wide[EXP_W-1:0];
         f = f_round;
      end
   end

endmodule

// File: rtl/fp_encode_seq.sv
// ---------------------------------------------------------------------------
// fp_encode_seq
// Sequential two's-complement to floating-point encoder (value = F * 2^E).
// The magnitude is normalised by shifting left one bit per cycle, then
// rounded to nearest with exponent saturation.
// Ports:
//   clk       in  1      rising-edge clock
//   rst       in  1      synchronous active-high reset
//   in_valid  in  1      d_in valid
//   in_ready  out 1      high only in IDLE (and never during reset)
//   d_in      in  IN_W   two's-complement sample
//   out_valid out 1      s/e/f valid
//   out_ready in  1      consumer accepts result
//   s         out 1      sign
//   e         out EXP_W  exponent
//   f         out MANT_W significand
// ---------------------------------------------------------------------------
module fp_encode_seq
   import fp_encode_seq_pkg::*;
#(
   parameter int IN_W   = DEF_IN_W,
   parameter int EXP_W  = DEF_EXP_W,
   parameter int MANT_W = DEF_MANT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IN_W-1:0]   d_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              s,
   output logic [EXP_W-1:0]  e,
   output logic [MANT_W-1:0] f
);

   localparam int                CNT_W    = cnt_w_of(IN_W, MANT_W);
   localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(IN_W - MANT_W);
   localparam logic [IN_W-1:0]   MOST_NEG = {1'b1, {(IN_W-1){1'b0}}};
   localparam logic [IN_W-1:0]   MOST_POS = {1'b0, {(IN_W-1){1'b1}}};

   state_t              state_reg;
   logic [IN_W-1:0]     mag_reg;
   logic [CNT_W-1:0]    cnt_reg;
   logic                s_reg;
   logic [EXP_W-1:0]    e_reg;
   logic [MANT_W-1:0]   f_reg;
   logic                out_valid_reg;

   logic [IN_W-1:0]     mag_in;
   logic                finish;
   logic [EXP_W-1:0]    round_e;
   logic [MANT_W-1:0]   round_f;

   // |d_in|; the most negative value has no positive twin and saturates.
   always_comb begin
      mag_in = d_in;
      if (d_in == MOST_NEG) begin
         mag_in = MOST_POS;
      end else if (d_in[IN_W-1]) begin
         mag_in = -d_in;
      end
   end

   // Stop once the leading one reaches the MSB or the shift budget is spent
   // (small values end up denormal with e = 0).
   assign finish = mag_reg[IN_W-1] | (cnt_reg == '0);

   fp_round #(
      .EXP_W  (EXP_W),
      .MANT_W (MANT_W),
      .CNT_W  (CNT_W)
   ) u_round (
      .f0  (mag_reg[IN_W-1 -: MANT_W]),
      .rb  (mag_reg[IN_W-1-MANT_W]),
      .cnt (cnt_reg),
      .e   (round_e),
      .f   (round_f)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         mag_reg       <= '0;
         cnt_reg       <= '0;
         s_reg         <= 1'b0;
         e_reg         <= '0;
         f_reg         <= '0;
         out_valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  s_reg     <= d_in[IN_W-1];
                  mag_reg   <= mag_in;
                  cnt_reg   <= CNT_INIT;
                  state_reg <= NORM;
               end
            end
            NORM: begin
               if (finish) begin
                  e_reg         <= round_e;
                  f_reg         <= round_f;
                  out_valid_reg <= 1'b1;
                  state_reg     <= DONE;
               end else begin
                  mag_reg <= mag_reg << 1;
                  cnt_reg <= cnt_reg - 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_reg <= 1'b0;
                  state_reg     <= IDLE;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = (state_reg == IDLE) && !rst;
   assign out_valid = out_valid_reg;
   assign s         = s_reg;
   assign e         = e_reg;
   assign f         = f_reg;

endmodule

// File: tb/tb_fp_encode_seq.sv
// ---------------------------------------------------------------------------
// tb_fp_encode_seq
// Self-checking bench for fp_encode_seq: a table of directed vectors with
// hand-computed results, a backpressure and a mid-conversion reset sequence,
// and random samples checked against a value-based reference model.
// ---------------------------------------------------------------------------
module tb_fp_encode_seq;

   localparam int IN_W   = 12;
   localparam int EXP_W  = 3;
   localparam int MANT_W = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [IN_W-1:0]   d_in;
   logic              out_valid;
   logic              out_ready;
   logic              s;
   logic [EXP_W-1:0]  e;
   logic [MANT_W-1:0] f;

   typedef struct {
      logic             s;
      logic [EXP_W-1:0] e;
      logic [MANT_W-1:0] f;
      int               lat;
   } exp_t;

   typedef struct {
      logic [IN_W-1:0]   d;
      logic              s;
      logic [EXP_W-1:0]  e;
      logic [MANT_W-1:0] f;
      int                lat;
      int                hold;
   } vec_t;

   exp_t sb[$];
   int   n_vec  = 0;
   int   n_cmp  = 0;
   int   n_fail = 0;

   fp_encode_seq #(
      .IN_W   (IN_W),
      .EXP_W  (EXP_W),
      .MANT_W (MANT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .d_in      (d_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .e         (e),
      .f         (f)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference: pick e so the magnitude fits in MANT_W bits, then round
   // half-up on the first dropped bit.
   function automatic exp_t model(input logic [IN_W-1:0] d);
      exp_t r;
      int   m, p, ee, ff, k;
      r.s = d[IN_W-1];
      if (d == 12'h800)      m = 2047;
      else if (d[IN_W-1])    m = 4096 - int'(d);
      else                   m = int'(d);
      p = -1;
      for (int i = 0; i < IN_W; i++) if (((m >> i) & 1) == 1) p = i;
      if (p < MANT_W) begin
         ee = 0;
         ff = m;
      end else begin
         ee = p - (MANT_W - 1);
         ff = (m + (1 << (ee - 1))) >> ee;
         if (ff == 16) begin
            ff = 8;
            ee = ee + 1;
         end
         if (ee > 7) begin
            ee = 7;
            ff = 15;
         end
      end
      k = (m == 0) ? 8 : (IN_W - 1 - p);
      if (k > 8) k = 8;
      r.e   = ee[EXP_W-1:0];
      r.f   = ff[MANT_W-1:0];
      r.lat = k + 2;
      return r;
   endfunction

   // Called #1 after a posedge with the DUT idle. Accept edge is edge 1.
   task automatic convert(input logic [IN_W-1:0] d, input exp_t x, input int hold);
      int   edges;
      bit   got;
      exp_t q;
      n_vec++;
      chk("in_ready_idle", int'(in_ready), 1);
      in_valid = 1'b1;
      d_in     = d;
      sb.push_back(x);
      @(posedge clk); #1;
      edges = 1;
      d_in  = IN_W'($urandom);   // in_valid left high: must be ignored
      got   = 1'b0;
      while (!got && edges < 30) begin
         if (out_valid) begin
            got = 1'b1;
         end else begin
            if (in_ready) chk("in_ready_busy", int'(in_ready), 0);
            @(posedge clk); #1;
            edges++;
            d_in = IN_W'($urandom);
         end
      end
      in_valid = 1'b0;
      if (!got) begin
         chk("out_valid_timeout", 0, 1);
         void'(sb.pop_front());
         return;
      end
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 0, 1);
         return;
      end
      q = sb.pop_front();
      chk("latency", edges, q.lat);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         chk("hold_valid", int'(out_valid), 1);
         chk("hold_in_ready", int'(in_ready), 0);
         chk("hold_e", int'(e), int'(q.e));
         chk("hold_f", int'(f), int'(q.f));
      end
      chk("s", int'(s), int'(q.s));
      chk("e", int'(e), int'(q.e));
      chk("f", int'(f), int'(q.f));
      $display("d_in=%0d s=%0d e=%0d f=%0d lat=%0d", $signed(d), s, e, f, edges);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("valid_drop", int'(out_valid), 0);
      chk("in_ready_back", int'(in_ready), 1);
   endtask

   initial begin
      vec_t vecs[14];
      exp_t x;
      logic [IN_W-1:0] rd;

      vecs = '{
         '{12'd0,    1'b0, 3'd0, 4'd0,  10, 1},
         '{12'd256,  1'b0, 3'd5, 4'd8,   5, 0},
         '{12'd62,   1'b0, 3'd3, 4'd8,   8, 0},
         '{12'hFC2,  1'b1, 3'd3, 4'd8,   8, 2},
         '{12'd2047, 1'b0, 3'd7, 4'd15,  3, 0},
         '{12'h800,  1'b1, 3'd7, 4'd15,  3, 0},
         '{12'd5,    1'b0, 3'd0, 4'd5,  10, 0},
         '{12'd1,    1'b0, 3'd0, 4'd1,  10, 0},
         '{12'd15,   1'b0, 3'd0, 4'd15, 10, 0},
         '{12'd16,   1'b0, 3'd1, 4'd8,   9, 0},
         '{12'd31,   1'b0, 3'd2, 4'd8,   9, 1},
         '{12'h780,  1'b0, 3'd7, 4'd15,  3, 0},
         '{12'hFFF,  1'b1, 3'd0, 4'd1,  10, 0},
         '{12'h400,  1'b0, 3'd7, 4'd8,   3, 1}
      };

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      d_in      = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_s", int'(s), 0);
      chk("rst_e", int'(e), 0);
      chk("rst_f", int'(f), 0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", int'(in_ready), 1);

      // Directed table
      for (int i = 0; i < 14; i++) begin
         x.s   = vecs[i].s;
         x.e   = vecs[i].e;
         x.f   = vecs[i].f;
         x.lat = vecs[i].lat;
         convert(vecs[i].d, x, vecs[i].hold);
      end

      // Backpressure: hold 256 for 5 cycles, then a second sample follows
      x = '{1'b0, 3'd5, 4'd8, 5};
      convert(12'd256, x, 5);
      x = '{1'b1, 3'd7, 4'd15, 3};
      convert(12'h800, x, 0);

      // Reset during NORM: conversion of 5 abandoned, no result emitted
      n_vec++;
      in_valid = 1'b1;
      d_in     = 12'd5;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_out_valid", int'(out_valid), 0);
      chk("midrst_s", int'(s), 0);
      chk("midrst_e", int'(e), 0);
      chk("midrst_f", int'(f), 0);
      chk("midrst_in_ready", int'(in_ready), 0);
      rst = 1'b0;
      #1;
      chk("midrst_in_ready_after", int'(in_ready), 1);
      for (int c = 0; c < 15; c++) begin
         @(posedge clk); #1;
         if (out_valid) chk("stale_result", int'(out_valid), 0);
      end
      chk("no_stale_result", int'(out_valid), 0);

      // Random samples against the reference model
      for (int r = 0; r < 24; r++) begin
         rd = IN_W'($urandom);
         if (r % 3 == 0) rd = rd >> $urandom_range(0, 11);
         convert(rd, model(rd), int'($urandom_range(0, 2)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
